// File: rtl/alu_pkg.sv
// Shared definitions for the chunked ALU: op encodings, FSM state type and
// the bit positions of the control word.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int unsigned CTL_INV_A = 3;
  localparam int unsigned CTL_INV_B = 2;
  localparam int unsigned CTL_OP_HI = 1;
  localparam int unsigned CTL_OP_LO = 0;

endpackage

// File: rtl/alu_slice.sv
// One CHUNK-bit combinational ALU slice.
// Ports: a_i/b_i operand slices, cin_i carry in; and_o/or_o/sum_o slice
// results, cout_o carry out of the slice MSB, msb_cin_o carry into the MSB.
module alu_slice #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] and_o,
  output logic [CHUNK-1:0] or_o,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  logic [CHUNK:0] full_sum;

  always_comb begin
    and_o     = a_i & b_i;
    or_o      = a_i | b_i;
    full_sum  = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    sum_o     = full_sum[CHUNK-1:0];
    cout_o    = full_sum[CHUNK];
    // sum = a ^ b ^ carry_in at every bit, so the MSB carry-in falls out directly
    msb_cin_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ full_sum[CHUNK-1];
  end

endmodule

// File: rtl/alu_chunked.sv
// Multi-cycle ALU processing CHUNK bits per cycle through a single shared slice.
// Ports: clk, rst_n (sync, active-low);
//   request:  in_valid, in_ready, a, b, cin, control[3:0]
//   response: out_valid, out_ready, result, cout, zero, overflow
module alu_chunked
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                carry_q, carry_d, cout_q, cout_d;
  logic                zero_q, zero_d, ovf_q, ovf_d;

  logic                last_slice;
  logic [31:0]         slice_lsb;
  logic [CHUNK-1:0]    sl_a, sl_b, sl_and, sl_or, sl_sum, sl_val;
  logic                sl_cout, sl_msb_cin, ovf_bit, slt_bit;

  assign last_slice = (cnt_q == CW'(N - 1));
  assign slice_lsb  = 32'(cnt_q) * 32'(CHUNK);
  assign sl_a       = CHUNK'(a_q >> slice_lsb);
  assign sl_b       = CHUNK'(b_q >> slice_lsb);

  alu_slice #(.CHUNK(CHUNK)) u_slice (
    .a_i      (sl_a),
    .b_i      (sl_b),
    .cin_i    (carry_q),
    .and_o    (sl_and),
    .or_o     (sl_or),
    .sum_o    (sl_sum),
    .cout_o   (sl_cout),
    .msb_cin_o(sl_msb_cin)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ovf_bit  = sl_msb_cin ^ sl_cout;
    slt_bit  = sl_sum[CHUNK-1] ^ ovf_bit;
    case (op_q)
      OP_AND:  sl_val = sl_and;
      OP_OR:   sl_val = sl_or;
      OP_ADD:  sl_val = sl_sum;
      default: sl_val = '0;
    endcase

    if (state_q == IDLE && in_valid) begin
      // Operands are stored already inverted so the slice sees final values
      a_d      = control[CTL_INV_A] ? ~a : a;
      b_d      = control[CTL_INV_B] ? ~b : b;
      op_d     = op_e'(control[CTL_OP_HI:CTL_OP_LO]);
      cnt_d    = '0;
      carry_d  = cin;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      zero_d   = 1'b1;
    end else if (state_q == BUSY) begin
      cnt_d    = cnt_q + 1'b1;
      carry_d  = sl_cout;
      result_d = result_q | (WIDTH'(sl_val) << slice_lsb);
      zero_d   = zero_q & (sl_val == '0);
      if (last_slice && op_q[1]) begin
        cout_d = sl_cout;
        ovf_d  = ovf_bit;
        if (op_q == OP_SLT) begin
          result_d = WIDTH'(slt_bit);
          zero_d   = ~slt_bit;
        end
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    cout      = cout_q;
    zero      = zero_q;
    overflow  = ovf_q;
  end

endmodule
